io_channels: RTL and testbench
==============================

# io_channels

Parametrised multi-channel input/output stream unit for the zero VM. It replaces the fixed `inMem`/`outMem` arrays and the free-running position counters with per-channel hardware FIFOs. External producers and consumers attach through valid/ready handshakes. The VM executes `inSize`, `in`, `out` and `outSize` as single-cycle requests. Both `NChannels` and the output-full policy (stall or overwrite oldest) are selectable.

## Interface
- `MemoryElementWidth`, default 12: data width W.
- `NChannels`, default 2: number of independent channel pairs. Must be at least 1.
- `NIn`, default 4: input FIFO depth per channel. Must be at most 2^W−1.
- `NOut`, default 8: output FIFO depth per channel. Must be at most 2^W−1.
- `OutOverwrite`, default 0: 0 = `out` to a full FIFO fails; 1 = oldest entry is discarded (ring behaviour).
- Derived: `CW` = max(1, $clog2(NChannels)).

- `clock`  in  1: single clock; everything is rising-edge.
- `reset`  in  1: asynchronous, active-low.
- `extInValid`  in  NChannels: producer has data for channel c.
- `extInData`  in  NChannels*W: channel c occupies bits [c*W +: W].
- `extInReady`  out  NChannels: input FIFO c is not full.
- `extOutValid`  out  NChannels: output FIFO c is not empty.
- `extOutData`  out  NChannels*W: head of output FIFO c; 0 when empty.
- `extOutReady`  in  NChannels: consumer takes the head.
- `req`  in  1: VM request this cycle.
- `op`  in  2: operation code; see Structure.
- `chan`  in  CW: target channel.
- `wdata`  in  W: data for `out`.
- `ack`  out  1: registered; high exactly one cycle after each `req`.
- `rdata`  out  W: registered result.
- `err`  out  1: registered; request failed.

## Operation
- Transfer rules:
  - External push into input FIFO c when `extInValid[c] & extInReady[c]`.
  - External pop from output FIFO c when `extOutValid[c] & extOutReady[c]`.
- VM ops are evaluated on pre-edge state. A request is sampled at rising edge N and completes at edge N; `ack`, `rdata` and `err` are visible after that edge.
  - IN_SIZE: `rdata` = input count of `chan`, zero-extended.
  - IN:
    - FIFO non-empty: pop; `rdata` = head; `err`=0.
    - FIFO empty: no pop; `rdata`=0; `err`=1.
  - OUT:
    - Accept if count < `NOut`, or if an external pop of the same channel occurs the same cycle.
    - Otherwise, `OutOverwrite`=1: drop head, append `wdata`, count stays `NOut`, `err`=0.
    - Otherwise, `OutOverwrite`=0: no change, `err`=1.
  - OUT_SIZE: `rdata` = output count of `chan`.
  - `chan` ≥ `NChannels`: no state change; `rdata`=0; `err`=1.
- Non-data ops (OUT, or any failure) return `rdata`=0.
- `ack`=0 cycles: `rdata` and `err` hold 0.

## Timing
- Reset values: all FIFOs empty; `ack`=`rdata`=`err`=0; `extInReady`=all 1; `extOutValid`=all 0; `extOutData`=0.
- Reset asserted mid-transfer clears every FIFO immediately. No partial transfer survives.
- `extInReady` and `extOutValid` depend combinationally on registered counts only. There is no combinational path from `extOutReady` or `req` to any output.
- Back-to-back requests are supported, one per cycle, with latency 1.
- External push and VM IN on the same channel in the same cycle: both occur and the count is unchanged. An empty FIFO returns `err`=1; the pushed word is not forwarded.
- A full input FIFO deasserts `extInReady` even if the VM pops in the same cycle. The push is accepted one cycle later.
- IN_SIZE and OUT_SIZE return the pre-edge count, excluding same-cycle external transfers.
- Read/write pointers wrap modulo depth. Counts are `$clog2(N+1)` bits wide.

## Structure
- Package `io_channel_pkg` holds:
  - op codes `IO_IN_SIZE`=0, `IO_IN`=1, `IO_OUT`=2, `IO_OUT_SIZE`=3;
  - typedef `io_op_t` (2-bit).
- Sub-module `io_fifo`, parametrised (W, DEPTH, OVERWRITE), provides push, pop, count, head, empty and full, with asynchronous active-low reset.
- `io_channels` instantiates 2×`NChannels` `io_fifo` instances plus the request decoder and registered response stage.

## Test plan
- Reset, then external push of 33, 22, 11 on channel 0. IN_SIZE ch0 → `rdata`=3. Three IN ops → `rdata` 33, 22, 11 with `err`=0. A fourth IN → `err`=1, `rdata`=0.
- OUT 1, 2, 3 on ch1 with `extOutReady`=0. OUT_SIZE ch1 → 3. Raise `extOutReady` → `extOutData` is 1, 2, 3 on successive cycles, then `extOutValid`=0.
- `OutOverwrite`=0, `NOut`=8: nine OUTs of 1..9 → ninth `err`=1. Drain yields 1..8.
- `OutOverwrite`=1: the same nine OUTs → all `err`=0. Drain yields 2..9.
- Input FIFO full (`NIn`=4): `extInReady`=0. VM IN plus external push in the same cycle → push lands on the next cycle, and the count returns to 4.
- `chan`=`NChannels` → `err`=1. Assert `reset` with both FIFOs half full → all counts 0, `extOutValid`=0, `ack`=0 immediately.

Source files
------------

// File: rtl/io_channel_pkg.sv
// Shared definitions for the zero VM I/O channel unit: request op codes and
// a helper that sizes the channel-select field.
package io_channel_pkg;

   typedef enum logic [1:0] {
      IO_IN_SIZE  = 2'd0,
      IO_IN       = 2'd1,
      IO_OUT      = 2'd2,
      IO_OUT_SIZE = 2'd3
   } io_op_t;

   // Width of the channel-select field; a single channel still needs one bit.
   function automatic int chan_width(input int nchannels);
      return (nchannels <= 1) ? 1 : $clog2(nchannels);
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock FIFO with a registered count. With OVERWRITE set, a push into a
// full FIFO (and no pop in the same cycle) discards the oldest entry so the
// new word is always stored.
module io_fifo #(
   parameter int W         = 12,
   parameter int DEPTH     = 4,
   parameter bit OVERWRITE = 1'b0,
   localparam int CNTW     = $clog2(DEPTH + 1),
   localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [W-1:0]    wdata,
   output logic [CNTW-1:0] count,
   output logic [W-1:0]    head,
   output logic            empty,
   output logic            full
);

   logic [W-1:0]    mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CNTW-1:0] count_q;
   logic            do_pop;
   logic            do_push;
   logic            do_drop;
   logic            advance_rd;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNTW'(DEPTH));
   assign do_pop     = pop & ~empty;
   // A full FIFO still takes a push when a pop frees a slot this cycle.
   assign do_drop    = push & full & ~do_pop & OVERWRITE;
   assign do_push    = push & (~full | do_pop | OVERWRITE);
   assign advance_rd = do_pop | do_drop;
   assign count      = count_q;
   assign head       = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy update; reset empties the FIFO at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (advance_rd) rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !advance_rd) count_q <= count_q + CNTW'(1);
         else if (!do_push && advance_rd) count_q <= count_q - CNTW'(1);
      end
   end

   // Storage array; contents are only visible while the count covers them.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/io_channels.sv
// Multi-channel input/output stream unit for the zero VM. Each channel owns an
// input FIFO (filled by an external producer, drained by VM IN) and an output
// FIFO (filled by VM OUT, drained by an external consumer). VM requests are
// evaluated on pre-edge state and answered one cycle later.
//
// Handshake rule for every ext* port pair: a word moves on a rising edge
// exactly when valid and ready are both high; valid never waits for ready, and
// ready/valid outputs come only from registered counts.
module io_channels
   import io_channel_pkg::*;
#(
   parameter int MemoryElementWidth = 12,
   parameter int NChannels          = 2,
   parameter int NIn                = 4,
   parameter int NOut               = 8,
   parameter bit OutOverwrite       = 1'b0,
   localparam int W                 = MemoryElementWidth,
   localparam int CW                = chan_width(NChannels)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NChannels-1:0]   extInValid,
   input  logic [NChannels*W-1:0] extInData,
   output logic [NChannels-1:0]   extInReady,
   output logic [NChannels-1:0]   extOutValid,
   output logic [NChannels*W-1:0] extOutData,
   input  logic [NChannels-1:0]   extOutReady,
   input  logic                   req,
   input  logic [1:0]             op,
   input  logic [CW-1:0]          chan,
   input  logic [W-1:0]           wdata,
   output logic                   ack,
   output logic [W-1:0]           rdata,
   output logic                   err
);

   localparam int INW  = $clog2(NIn + 1);
   localparam int OUTW = $clog2(NOut + 1);

   logic [NChannels-1:0] in_push, in_pop, in_empty, in_full;
   logic [NChannels-1:0] out_push, out_pop, out_empty, out_full;
   logic [INW-1:0]       in_count  [NChannels];
   logic [OUTW-1:0]      out_count [NChannels];
   logic [W-1:0]         in_head   [NChannels];
   logic [W-1:0]         out_head  [NChannels];

   io_op_t          req_op;
   logic            chan_ok;
   logic            is_in;
   logic            is_out;
   logic [INW-1:0]  sel_in_count;
   logic            sel_in_empty;
   logic [W-1:0]    sel_in_head;
   logic [OUTW-1:0] sel_out_count;
   logic            sel_out_full;
   logic            sel_out_pop;
   logic [W-1:0]    resp_rdata;
   logic            resp_err;

   assign req_op  = io_op_t'(op);
   assign chan_ok = (int'(chan) < NChannels);
   assign is_in   = req & chan_ok & (req_op == IO_IN);
   assign is_out  = req & chan_ok & (req_op == IO_OUT);

   for (genvar c = 0; c < NChannels; c++) begin : g_chan
      logic sel;
      assign sel = (int'(chan) == c);

      // A full input FIFO refuses the producer even if the VM pops this cycle.
      assign in_push[c]  = extInValid[c] & ~in_full[c];
      assign in_pop[c]   = is_in & sel & ~in_empty[c];
      assign out_pop[c]  = extOutReady[c] & ~out_empty[c];
      assign out_push[c] = is_out & sel & (~out_full[c] | out_pop[c] | OutOverwrite);

      io_fifo #(.W(W), .DEPTH(NIn), .OVERWRITE(1'b0)) u_in_fifo (
         .clock (clock),
         .reset (reset),
         .push  (in_push[c]),
         .pop   (in_pop[c]),
         .wdata (extInData[c*W +: W]),
         .count (in_count[c]),
         .head  (in_head[c]),
         .empty (in_empty[c]),
         .full  (in_full[c])
      );

      io_fifo #(.W(W), .DEPTH(NOut), .OVERWRITE(OutOverwrite)) u_out_fifo (
         .clock (clock),
         .reset (reset),
         .push  (out_push[c]),
         .pop   (out_pop[c]),
         .wdata (wdata),
         .count (out_count[c]),
         .head  (out_head[c]),
         .empty (out_empty[c]),
         .full  (out_full[c])
      );

      assign extInReady[c]         = ~in_full[c];
      assign extOutValid[c]        = ~out_empty[c];
      assign extOutData[c*W +: W]  = out_head[c];
   end

   // Pick the addressed channel's FIFO status for the request decoder.
   always_comb begin
      sel_in_count  = '0;
      sel_in_empty  = 1'b1;
      sel_in_head   = '0;
      sel_out_count = '0;
      sel_out_full  = 1'b0;
      sel_out_pop   = 1'b0;
      for (int c = 0; c < NChannels; c++) begin
         if (int'(chan) == c) begin
            sel_in_count  = in_count[c];
            sel_in_empty  = in_empty[c];
            sel_in_head   = in_head[c];
            sel_out_count = out_count[c];
            sel_out_full  = out_full[c];
            sel_out_pop   = out_pop[c];
         end
      end
   end

   // Decode the request into its response; failures and OUT return zero data.
   always_comb begin
      resp_rdata = '0;
      resp_err   = 1'b0;
      if (req) begin
         if (!chan_ok) begin
            resp_err = 1'b1;
         end else begin
            case (req_op)
               IO_IN_SIZE:  resp_rdata = W'(sel_in_count);
               IO_IN: begin
                  if (sel_in_empty) resp_err = 1'b1;
                  else resp_rdata = sel_in_head;
               end
               IO_OUT: begin
                  if (sel_out_full && !sel_out_pop && !OutOverwrite) resp_err = 1'b1;
               end
               IO_OUT_SIZE: resp_rdata = W'(sel_out_count);
               default:     resp_err = 1'b1;
            endcase
         end
      end
   end

   // Registered response stage: one-cycle latency, zeros when idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ack   <= 1'b0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         ack   <= req;
         rdata <= resp_rdata;
         err   <= resp_err;
      end
   end

endmodule

// File: tb/tb_io_channels.sv
// Directed bench for io_channels. Two instances share all inputs: one with the
// stall policy on a full output FIFO, one with overwrite-oldest. Three channels
// are used so that an out-of-range channel number can be expressed.
module tb_io_channels;
   import io_channel_pkg::*;

   localparam int W    = 12;
   localparam int N_CH = 3;
   localparam int CW   = 2;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [N_CH-1:0]   ext_in_valid;
   logic [N_CH*W-1:0] ext_in_data;
   logic [N_CH-1:0]   ext_out_ready;
   logic              req;
   logic [1:0]        op;
   logic [CW-1:0]     chan;
   logic [W-1:0]      wdata;

   logic [N_CH-1:0]   in_ready_s, out_valid_s, in_ready_o, out_valid_o;
   logic [N_CH*W-1:0] out_data_s, out_data_o;
   logic              ack_s, err_s, ack_o, err_o;
   logic [W-1:0]      rdata_s, rdata_o;

   io_channels #(.MemoryElementWidth(W), .NChannels(N_CH), .NIn(4), .NOut(8),
                 .OutOverwrite(1'b0)) dut_s (
      .clock(clock), .reset(reset),
      .extInValid(ext_in_valid), .extInData(ext_in_data), .extInReady(in_ready_s),
      .extOutValid(out_valid_s), .extOutData(out_data_s), .extOutReady(ext_out_ready),
      .req(req), .op(op), .chan(chan), .wdata(wdata),
      .ack(ack_s), .rdata(rdata_s), .err(err_s)
   );

   io_channels #(.MemoryElementWidth(W), .NChannels(N_CH), .NIn(4), .NOut(8),
                 .OutOverwrite(1'b1)) dut_o (
      .clock(clock), .reset(reset),
      .extInValid(ext_in_valid), .extInData(ext_in_data), .extInReady(in_ready_o),
      .extOutValid(out_valid_o), .extOutData(out_data_o), .extOutReady(ext_out_ready),
      .req(req), .op(op), .chan(chan), .wdata(wdata),
      .ack(ack_o), .rdata(rdata_o), .err(err_o)
   );

   // scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_o_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // driver tasks (called #1 after a rising edge)
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic vm_req(input io_op_t o, input logic [CW-1:0] c, input logic [W-1:0] d);
      req   = 1'b1;
      op    = o;
      chan  = c;
      wdata = d;
      cycle();
      req   = 1'b0;
      op    = 2'd0;
      chan  = '0;
      wdata = '0;
   endtask

   task automatic ext_push(input int c, input logic [W-1:0] d);
      ext_in_valid[c]        = 1'b1;
      ext_in_data[c*W +: W]  = d;
      cycle();
      ext_in_valid[c]        = 1'b0;
   endtask

   task automatic check_resp(input string tag, input logic [W-1:0] exp_rdata, input logic exp_err);
      check_eq({tag, "_ack"}, ack_s, 1);
      check_eq({tag, "_rdata"}, rdata_s, exp_rdata);
      check_eq({tag, "_err"}, err_s, exp_err);
   endtask

   // Drain output FIFO c of both instances against the expected queues.
   task automatic drain(input int c, input string tag);
      ext_out_ready[c] = 1'b1;
      while (exp_q.size() > 0) begin
         check_eq({tag, "_valid"}, out_valid_s[c], 1);
         check_eq({tag, "_data"}, out_data_s[c*W +: W], exp_q.pop_front());
         if (exp_o_q.size() > 0)
            check_eq({tag, "_o_data"}, out_data_o[c*W +: W], exp_o_q.pop_front());
         cycle();
      end
      ext_out_ready[c] = 1'b0;
      check_eq({tag, "_end_valid"}, out_valid_s[c], 0);
      check_eq({tag, "_end_data"}, out_data_s[c*W +: W], 0);
      check_eq({tag, "_end_o_valid"}, out_valid_o[c], 0);
   endtask

   initial begin
      ext_in_valid  = '0;
      ext_in_data   = '0;
      ext_out_ready = '0;
      req           = 1'b0;
      op            = 2'd0;
      chan          = '0;
      wdata         = '0;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_ack", ack_s, 0);
      check_eq("rst_rdata", rdata_s, 0);
      check_eq("rst_err", err_s, 0);
      check_eq("rst_in_ready", in_ready_s, 3'b111);
      check_eq("rst_out_valid", out_valid_s, 0);
      check_eq("rst_out_data", out_data_s, 0);
      @(negedge clock);
      reset = 1'b1;
      cycle();

      // input path: push 33, 22, 11 and read them back
      ext_push(0, 12'd33);
      ext_push(0, 12'd22);
      ext_push(0, 12'd11);
      vm_req(IO_IN_SIZE, 2'd0, '0);
      check_resp("in_size3", 12'd3, 1'b0);
      vm_req(IO_IN, 2'd0, '0);
      check_resp("in_33", 12'd33, 1'b0);
      vm_req(IO_IN, 2'd0, '0);
      check_resp("in_22", 12'd22, 1'b0);
      vm_req(IO_IN, 2'd0, '0);
      check_resp("in_11", 12'd11, 1'b0);
      vm_req(IO_IN, 2'd0, '0);
      check_resp("in_empty", 12'd0, 1'b1);
      cycle();
      check_eq("idle_ack", ack_s, 0);
      check_eq("idle_rdata", rdata_s, 0);
      check_eq("idle_err", err_s, 0);

      // output path: OUT 1, 2, 3 on ch1 then drain
      for (int i = 1; i <= 3; i++) begin
         vm_req(IO_OUT, 2'd1, W'(i));
         check_resp("out_123", 12'd0, 1'b0);
         exp_q.push_back(W'(i));
         exp_o_q.push_back(W'(i));
      end
      vm_req(IO_OUT_SIZE, 2'd1, '0);
      check_resp("out_size3", 12'd3, 1'b0);
      drain(1, "drain123");

      // full output FIFO: stall versus overwrite
      for (int i = 1; i <= 9; i++) begin
         vm_req(IO_OUT, 2'd1, W'(i));
         check_eq("ovf_s_err", err_s, (i == 9));
         check_eq("ovf_o_err", err_o, 0);
      end
      vm_req(IO_OUT_SIZE, 2'd1, '0);
      check_eq("ovf_s_size", rdata_s, 8);
      check_eq("ovf_o_size", rdata_o, 8);
      for (int i = 1; i <= 8; i++) exp_q.push_back(W'(i));
      for (int i = 2; i <= 9; i++) exp_o_q.push_back(W'(i));
      drain(1, "drain_ovf");

      // full input FIFO: VM pop and blocked push in the same cycle
      for (int i = 5; i <= 8; i++) ext_push(0, W'(i));
      check_eq("inf_ready0", in_ready_s[0], 0);
      vm_req(IO_IN_SIZE, 2'd0, '0);
      check_resp("inf_size4", 12'd4, 1'b0);
      ext_in_valid[0]     = 1'b1;
      ext_in_data[11:0]   = 12'd9;
      vm_req(IO_IN, 2'd0, '0);
      check_resp("inf_pop5", 12'd5, 1'b0);
      check_eq("inf_ready1", in_ready_s[0], 1);
      cycle();
      ext_in_valid[0]     = 1'b0;
      check_eq("inf_ready_again0", in_ready_s[0], 0);
      vm_req(IO_IN_SIZE, 2'd0, '0);
      check_resp("inf_size_back4", 12'd4, 1'b0);
      for (int i = 6; i <= 9; i++) begin
         vm_req(IO_IN, 2'd0, '0);
         check_resp("inf_drain", W'(i), 1'b0);
      end

      // out-of-range channel
      vm_req(IO_IN_SIZE, 2'd3, '0);
      check_resp("bad_chan_size", 12'd0, 1'b1);
      vm_req(IO_OUT, 2'd3, 12'd7);
      check_resp("bad_chan_out", 12'd0, 1'b1);

      // reset with FIFOs half full and a response on the outputs
      ext_push(0, 12'd1);
      ext_push(0, 12'd2);
      for (int i = 1; i <= 4; i++) vm_req(IO_OUT, 2'd1, W'(i));
      check_eq("pre_rst_valid", out_valid_s[1], 1);
      vm_req(IO_OUT_SIZE, 2'd1, '0);
      check_resp("pre_rst_size", 12'd4, 1'b0);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_ack", ack_s, 0);
      check_eq("mid_rst_rdata", rdata_s, 0);
      check_eq("mid_rst_in_ready", in_ready_s, 3'b111);
      check_eq("mid_rst_out_valid", out_valid_s, 0);
      check_eq("mid_rst_out_data", out_data_s, 0);
      check_eq("mid_rst_o_valid", out_valid_o, 0);
      @(negedge clock);
      reset = 1'b1;
      cycle();
      vm_req(IO_IN_SIZE, 2'd0, '0);
      check_resp("post_rst_in_size", 12'd0, 1'b0);
      vm_req(IO_OUT_SIZE, 2'd1, '0);
      check_resp("post_rst_out_size", 12'd0, 1'b0);

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
